uart_tx_periph: RTL

- Memory-mapped UART transmitter. Sits as a responder on the CPU peripheral bus (rd/wr/addr/wdata/rdata) and drives the serial UART_TX line.
- The CPU writes bytes into a small TX FIFO. The block serialises them as 8N1 frames, LSB first, using an internal baud divider.
- It reports busy, full, empty, done and overflow status, and raises a level interrupt on frame completion.

---
 rtl/uart_tx_periph_pkg.sv | 29 ++
 rtl/uart_tx_periph_fifo.sv | 53 +++++
 rtl/uart_tx_periph.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_periph_pkg.sv
// Shared register map, STATUS bit positions and transmitter state encoding.
// Address match helper compares word addresses only; byte-lane bits are ignored.
package uart_tx_periph_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;
  localparam logic [31:0] CTRL_OFS   = 32'd8;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_DONE      = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic word_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] ofs);
    return (addr & ~32'h3) == ((base & ~32'h3) + ofs);
  endfunction

endpackage

// File: rtl/uart_tx_periph_fifo.sv
// Byte FIFO for the UART transmitter; push visible in count/dout one edge later.
// Push on full is dropped unless a pop happens in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud/bit sequencer, status and irq.
// Line falls one edge after the FIFO goes non-empty; writes to a full FIFO set ovf.
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h40000030,
  parameter int          CLKS_PER_BIT = 2604,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout,
  output logic        UART_TX
);

  localparam int             BW          = $clog2(CLKS_PER_BIT);
  localparam int             CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  tx_state_e       state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            done, ovf, ien;

  logic            fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;

  logic            hit_txdata, hit_status, hit_ctrl;
  logic            wr_txdata, wr_ctrl;
  logic            bit_end, frame_end, ovf_set;
  logic            unused_wdata;

  assign hit_txdata = word_hit(addr, BASE_ADDR, TXDATA_OFS);
  assign hit_status = word_hit(addr, BASE_ADDR, STATUS_OFS);
  assign hit_ctrl   = word_hit(addr, BASE_ADDR, CTRL_OFS);
  assign wr_txdata  = wr && hit_txdata;
  assign wr_ctrl    = wr && hit_ctrl;

  assign bit_end    = (baud_cnt == '0);
  assign frame_end  = (state == STOP) && bit_end;
  // Pop either from idle or at the end of a stop bit so frames run back to back.
  assign fifo_pop   = !fifo_empty && ((state == IDLE) || frame_end);
  assign fifo_push  = wr_txdata;
  assign ovf_set    = wr_txdata && fifo_full && !fifo_pop;

  assign unused_wdata = ^wdata[31:8];

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      UART_TX  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          UART_TX <= 1'b1;
          if (fifo_pop) begin
            shift    <= fifo_dout;
            baud_cnt <= BAUD_RELOAD;
            state    <= START;
            UART_TX  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= DATA;
            UART_TX  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              UART_TX <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              shift    <= fifo_dout;
              baud_cnt <= BAUD_RELOAD;
              state    <= START;
              UART_TX  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Hardware set beats a software clear landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
      ovf  <= 1'b0;
      ien  <= 1'b0;
    end else begin
      if (wr_ctrl) ien <= wdata[0];
      if (frame_end)                done <= 1'b1;
      else if (wr_ctrl && wdata[1]) done <= 1'b0;
      if (ovf_set)                  ovf  <= 1'b1;
      else if (wr_ctrl && wdata[2]) ovf  <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (hit_status) begin
        rdata[ST_BUSY]               = (state != IDLE);
        rdata[ST_FULL]               = fifo_full;
        rdata[ST_EMPTY]              = fifo_empty;
        rdata[ST_DONE]               = done;
        rdata[ST_OVF]                = ovf;
        rdata[ST_COUNT_LSB +: CW]    = fifo_count;
      end else if (hit_ctrl) begin
        rdata[0] = ien;
      end
    end
  end

  assign irqout = ien && done;

endmodule
